// File: rtl/hold_arb85.sv
// Bus-hold arbiter for the 8085 core: sequences HOLD/HLDA so NREQ requesters
// take turns on the bus, round-robin, with an optional tenure limit.
module hold_arb85 #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int MAXHOLD = 16,
  parameter int CNTW    = 8
) (
  input  logic            clk,
  input  logic            rst_,
  input  logic [NREQ-1:0] dreq,
  input  logic            hlda,
  output logic            hold,
  output logic [NREQ-1:0] dack,
  output logic            busy,
  output logic [IDW-1:0]  grant_id,
  output logic [2:0]      dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQH  = 3'd1,
    GRANT = 3'd2,
    RELS  = 3'd3,
    WAITL = 3'd4
  } state_t;

  localparam logic [CNTW-1:0] LIMIT   = (MAXHOLD == 0) ? '0 : CNTW'(MAXHOLD - 1);
  localparam logic [CNTW-1:0] CNT_MAX = '1;

  // Handshake: hold stays high from REQH through GRANT; a requester may drive
  // the bus only while its dack bit is high, and dack only rises after hlda.
  state_t          state;
  logic [IDW-1:0]  rr_ptr;
  logic [CNTW-1:0] cnt;
  logic [IDW-1:0]  pick;
  logic [IDW-1:0]  next_ptr;
  logic [NREQ-1:0] own_mask;
  logic            own_req;
  logic            others;
  logic            tenure_up;

  // First set request at or above ptr, wrapping; lower offsets overwrite later.
  function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                             input logic [IDW-1:0]  ptr);
    int             idx;
    logic [IDW-1:0] sel;
    rr_pick = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      sel = IDW'(idx);
      if (req[sel]) rr_pick = sel;
    end
  endfunction

  assign pick      = rr_pick(dreq, rr_ptr);
  assign own_mask  = {{(NREQ-1){1'b0}}, 1'b1} << grant_id;
  assign own_req   = dreq[grant_id];
  assign others    = |(dreq & ~own_mask);
  assign tenure_up = (MAXHOLD != 0) && (cnt >= LIMIT) && others;
  assign next_ptr  = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state    <= IDLE;
      hold     <= 1'b0;
      dack     <= '0;
      busy     <= 1'b0;
      grant_id <= '0;
      rr_ptr   <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|dreq) begin
            grant_id <= pick;
            hold     <= 1'b1;
            busy     <= 1'b1;
            state    <= REQH;
          end
        end
        REQH: begin
          if (hlda && own_req) begin
            dack  <= own_mask;
            cnt   <= '0;
            state <= GRANT;
          end else if (!own_req) begin
            hold  <= 1'b0;
            state <= RELS;
          end
        end
        GRANT: begin
          // Losing hlda mid-grant is a core protocol error: give the bus back.
          if (!own_req || !hlda || tenure_up) begin
            dack  <= '0;
            hold  <= 1'b0;
            state <= RELS;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        RELS: begin
          rr_ptr <= next_ptr;
          state  <= WAITL;
        end
        WAITL: begin
          if (!hlda) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          hold  <= 1'b0;
          dack  <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hold_arb85.sv
// Self-checking bench for hold_arb85: directed vector table, hand sequences
// for multi-cycle corners, and random traffic against a behavioural model.
module tb_hold_arb85;

  localparam int NREQ    = 4;
  localparam int IDW     = 2;
  localparam int MAXHOLD = 16;
  localparam int CNTW    = 8;
  localparam int W       = 2 + NREQ + IDW;

  logic            clk = 1'b0;
  logic            rst_ = 1'b0;
  logic [NREQ-1:0] dreq = '0;
  logic            hlda = 1'b0;
  logic            hold;
  logic [NREQ-1:0] dack;
  logic            busy;
  logic [IDW-1:0]  grant_id;
  logic [2:0]      dbg_state;

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] exp_q[$];

  // Behavioural model: tracks the visible bus ownership, not an FSM encoding.
  logic            m_hold, m_busy, m_rels;
  logic [NREQ-1:0] m_dack;
  int              m_gid, m_ptr, m_ten;

  typedef struct {
    logic [NREQ-1:0] dreq;
    logic            hlda;
    logic            hold;
    logic [NREQ-1:0] dack;
    logic            busy;
    logic [IDW-1:0]  gid;
  } vec_t;

  vec_t tbl[26];

  always #5 clk = ~clk;

  hold_arb85 #(.NREQ(NREQ), .IDW(IDW), .MAXHOLD(MAXHOLD), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst_      (rst_),
    .dreq      (dreq),
    .hlda      (hlda),
    .hold      (hold),
    .dack      (dack),
    .busy      (busy),
    .grant_id  (grant_id),
    .dbg_state (dbg_state)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic check_outs(input string name, input logic e_hold, input logic [NREQ-1:0] e_dack,
                            input logic e_busy, input logic [IDW-1:0] e_gid);
    check({name, "_hold"}, hold, e_hold);
    check({name, "_dack"}, dack, e_dack);
    check({name, "_busy"}, busy, e_busy);
    check({name, "_gid"}, grant_id, e_gid);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_ = 1'b0;
    dreq = '0;
    hlda = 1'b0;
    repeat (2) @(negedge clk);
    rst_ = 1'b1;
    m_hold = 1'b0; m_busy = 1'b0; m_rels = 1'b0; m_dack = '0;
    m_gid = 0; m_ptr = 0; m_ten = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic [NREQ-1:0] d, input logic h);
    if (!m_busy) begin
      if (d != '0) begin
        for (int k = 0; k < NREQ; k++) begin
          if (d[(m_ptr + k) % NREQ]) begin
            m_gid = (m_ptr + k) % NREQ;
            break;
          end
        end
        m_hold = 1'b1;
        m_busy = 1'b1;
      end
    end else if (m_rels) begin
      m_rels = 1'b0;
      m_ptr  = (m_gid + 1) % NREQ;
    end else if (m_dack != '0) begin
      if (!d[m_gid] || !h || (MAXHOLD != 0 && m_ten >= MAXHOLD - 1 && (d & ~m_dack) != '0)) begin
        m_dack = '0;
        m_hold = 1'b0;
        m_rels = 1'b1;
      end else begin
        m_ten++;
      end
    end else if (m_hold) begin
      if (h && d[m_gid]) begin
        m_dack = NREQ'(1 << m_gid);
        m_ten  = 0;
      end else if (!d[m_gid]) begin
        m_hold = 1'b0;
        m_rels = 1'b1;
      end
    end else if (!h) begin
      m_busy = 1'b0;
    end
    exp_q.push_back({m_hold, m_busy, m_dack, IDW'(m_gid)});
  endtask

  // Core stand-in: hlda follows hold one cycle later; waits for a grant.
  task automatic wait_grant(output logic [NREQ-1:0] g, output logic idle_seen);
    int n;
    n = 0;
    idle_seen = (!busy && !hold);
    while (dack == '0 && n < 60) begin
      hlda = hold;
      tick();
      n++;
      if (!busy && !hold) idle_seen = 1'b1;
    end
    check("grant_wait_in_budget", (n < 60), 1'b1);
    g = dack;
  endtask

  initial begin
    logic [NREQ-1:0] g;
    logic            idle;
    logic [NREQ-1:0] rr_exp[4];
    logic [W-1:0]    e;
    int              cnt;
    int              n;

    tbl = '{
      '{4'b0100, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd2},
      '{4'b0100, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd2},
      '{4'b0100, 1'b1, 1'b1, 4'b0100, 1'b1, 2'd2},
      '{4'b0100, 1'b1, 1'b1, 4'b0100, 1'b1, 2'd2},
      '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd2},
      '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd2},
      '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd2},
      '{4'b1011, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd3},
      '{4'b1011, 1'b1, 1'b1, 4'b1000, 1'b1, 2'd3},
      '{4'b0011, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd3},
      '{4'b0011, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd3},
      '{4'b0011, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd3},
      '{4'b0011, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd0},
      '{4'b0010, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0},
      '{4'b0010, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0},
      '{4'b0010, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0},
      '{4'b0010, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd1},
      '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd1},
      '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd1},
      '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd1},
      '{4'b0111, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd2},
      '{4'b0111, 1'b1, 1'b1, 4'b0100, 1'b1, 2'd2},
      '{4'b0111, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd2},
      '{4'b0111, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd2},
      '{4'b0111, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd2},
      '{4'b0111, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd0}
    };
    rr_exp = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};

    // Reset held with every request asserted.
    rst_ = 1'b0;
    dreq = 4'b1111;
    repeat (3) begin
      @(negedge clk);
      check_outs("in_reset", 1'b0, 4'b0000, 1'b0, 2'd0);
    end
    rst_ = 1'b1;
    check_outs("reset_release", 1'b0, 4'b0000, 1'b0, 2'd0);
    tick();
    check_outs("first_eval", 1'b1, 4'b0000, 1'b1, 2'd0);

    // Directed vector table.
    do_reset();
    for (int i = 0; i < 26; i++) begin
      dreq = tbl[i].dreq;
      hlda = tbl[i].hlda;
      tick();
      check_outs($sformatf("vec%0d", i), tbl[i].hold, tbl[i].dack, tbl[i].busy, tbl[i].gid);
    end

    // Round-robin with three-cycle tenures.
    do_reset();
    dreq = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      wait_grant(g, idle);
      check($sformatf("rr_order%0d", i), g, rr_exp[i]);
      check($sformatf("rr_idle_gap%0d", i), idle, 1'b1);
      repeat (2) begin
        hlda = hold;
        tick();
        check("rr_tenure", dack, g);
      end
      dreq = dreq & ~g;
      hlda = hold;
      tick();
      check("rr_release", {hold, dack}, '0);
      dreq = dreq | g;
    end

    // Tenure limit preemption.
    do_reset();
    dreq = 4'b0001;
    wait_grant(g, idle);
    check("pre_first", g, 4'b0001);
    cnt = 1;
    n = 0;
    while (dack == 4'b0001 && n < 100) begin
      if (cnt == 5) dreq = 4'b0101;
      hlda = hold;
      tick();
      n++;
      if (dack == 4'b0001) cnt++;
    end
    check("pre_tenure_cycles", cnt, MAXHOLD);
    check("pre_hold_low", hold, 1'b0);
    wait_grant(g, idle);
    check("pre_second", g, 4'b0100);
    dreq = 4'b0001;
    hlda = hold;
    tick();
    wait_grant(g, idle);
    check("pre_third", g, 4'b0001);

    // Asynchronous reset mid-grant.
    do_reset();
    dreq = 4'b1000;
    tick();
    hlda = 1'b1;
    tick();
    check("ar_grant", dack, 4'b1000);
    #2 rst_ = 1'b0;
    #1 check_outs("ar_immediate", 1'b0, 4'b0000, 1'b0, 2'd0);
    @(negedge clk);
    rst_ = 1'b1;
    dreq = '0;
    hlda = 1'b0;
    tick();
    check_outs("ar_idle", 1'b0, 4'b0000, 1'b0, 2'd0);

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < NREQ; b++)
        if ($urandom_range(0, 15) == 0) dreq[b] = ~dreq[b];
      if (hlda != hold && $urandom_range(0, 1) == 1) hlda = hold;
      else if (hlda && hold && $urandom_range(0, 63) == 0) hlda = 1'b0;
      @(posedge clk);
      model_step(dreq, hlda);
      @(negedge clk);
      e = exp_q.pop_front();
      check("rand", {hold, busy, dack, grant_id}, e);
      if (dack != '0 && !hold) check("rand_dack_needs_hold", 1'b0, 1'b1);
      if ((dack & (dack - 1'b1)) != '0) check("rand_dack_onehot", dack, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hold_arb85.md
Name: hold_arb85

Overview:
- Bus-hold arbiter for the 8085 core. Shares the core's address/data bus among NREQ DMA-style requesters by sequencing the core's HOLD/HLDA handshake.
- Grants one requester at a time, round-robin, with an optional tenure limit. The core regains the bus between every grant.
- Sits beside the core: drives its hold input and samples its hlda output.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of grant_id; NREQ <= 2**IDW.
- MAXHOLD, 16, max GRANT cycles when another requester is pending; 0 = unlimited.
- CNTW, 8, tenure counter width; MAXHOLD < 2**CNTW.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_  in  1  reset, asynchronous, active-low.
- dreq  in  NREQ  per-requester bus request, level, held high while bus wanted.
- hlda  in  1  hold acknowledge from core.
- hold  out  1  hold request to core.
- dack  out  NREQ  one-hot grant; requester may drive bus only while its bit is high.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  IDW  index of current/last winner.

Behaviour:
- Reset (rst_ low, asynchronous): state=IDLE, hold=0, dack=0, busy=0, grant_id=0, rr pointer=0, counter=0. Applies immediately, including mid-grant. No handshake completion.
- All outputs are registered. Decisions use inputs sampled at the rising edge.
- States: IDLE, REQH, GRANT, RELS, WAITL.
- IDLE: if any dreq is set, pick the first set bit searching from rr pointer upward with wrap (pointer itself first). Latch it into grant_id, set hold=1, go REQH. Otherwise stay in IDLE.
- REQH: hold=1. Wait for hlda=1.
  - hlda=1 and dreq[grant_id]=1: go GRANT with dack[grant_id]=1 and counter=0.
  - dreq[grant_id]=0 (winner withdrew) before hlda: go RELS with no grant issued. No re-arbitration inside REQH.
- GRANT: hold=1, dack one-hot. Counter increments each cycle and saturates. Exit to RELS when any of the following holds:
  - dreq[grant_id]=0;
  - MAXHOLD!=0, counter>=MAXHOLD-1, and any other dreq=1 (preemption);
  - hlda=0 (protocol error).
- RELS: single cycle. dack=0, hold=0. rr pointer = grant_id+1, wrapping at NREQ (also applied on a REQH withdrawal). Go WAITL.
- WAITL: hold=0. Wait for hlda=0, then go IDLE.
- Core access: IDLE lasts at least 1 cycle after every grant, even with requests pending, so the core regains the bus.
- Latency:
  - dreq rise in IDLE to hold=1: 1 cycle.
  - hlda sampled high to dack high: 1 cycle.
  - dreq drop to dack low and hold low: 1 cycle, both in the same cycle.
- Preempted requester: sees dack low and must stop driving immediately. It may keep dreq high and is served again in round-robin order.
- Requests arriving during REQH/GRANT/RELS/WAITL are only evaluated in IDLE.
- Simultaneous dreq: priority rotates from pointer. With pointer=0, lowest index wins.
- busy=0 only in IDLE. dack is never multi-hot, and never high while hold=0.

Test Plan:
- Reset: hold rst_ low 3 clk with dreq=4'b1111, release -> hold=0, dack=0, grant_id=0 until first IDLE evaluation; then grant_id=0, hold=1.
- Single requester: dreq=4'b0100, core returns hlda 2 cycles after hold -> dack=4'b0100 1 cycle after hlda. Drop dreq -> next cycle dack=0, hold=0. Drop hlda -> IDLE, busy=0; pointer=3.
- Round-robin: dreq=4'b1011 held, requesters drop after 3 grant cycles each -> grant order 0,1,3,0. Each grant separated by at least 1 IDLE cycle with hold=0.
- Preemption, MAXHOLD=16: dreq[0] held forever, dreq[2] raised at grant cycle 5 -> dack[0] drops after 16 GRANT cycles. Next grant goes to 2, then 0 again.
- Withdrawal in REQH: dreq=4'b0010 pulsed for 2 cycles while hlda held low -> no dack ever; hold drops 1 cycle after dreq falls; pointer=2.
- Async reset mid-GRANT: rst_ low between clock edges with dack=4'b1000 -> dack=0, hold=0 immediately, without waiting for a clock edge; state IDLE after release.
